lcd_display_ctrl: RTL and testbench



---
 rtl/lcd_pkg.sv | 48 ++++
 rtl/lcd_byte_sender.sv | 84 ++++++++
 rtl/lcd_display_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_lcd_display_ctrl.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared types and constants for the character-LCD sequencer and its byte sender.
package lcd_pkg;

   typedef enum logic [2:0] {
      PWR_WAIT,
      INIT_SEND,
      CLR_WAIT,
      IDLE,
      ROW_ADDR,
      ROW_CHARS
   } lcd_state_t;

   typedef enum logic [1:0] {
      SND_IDLE,
      SND_REQ,
      SND_RELEASE
   } snd_state_t;

   // HD44780 4-bit power-up sequence, sent in this order as commands
   localparam logic [7:0] LCD_INIT_0 = 8'h33;
   localparam logic [7:0] LCD_INIT_1 = 8'h32;
   localparam logic [7:0] LCD_INIT_2 = 8'h28;
   localparam logic [7:0] LCD_INIT_3 = 8'h0C;
   localparam logic [7:0] LCD_INIT_4 = 8'h06;
   localparam logic [7:0] LCD_INIT_5 = 8'h01;
   localparam logic [2:0] LCD_INIT_LAST = 3'd5;

   localparam logic [7:0] LCD_CMD_ROW1  = 8'h80;
   localparam logic [7:0] LCD_CMD_ROW2  = 8'hC0;
   localparam logic [7:0] LCD_CMD_CLEAR = 8'h01;

   // Two address commands plus 2 x 16 characters per redraw
   localparam int LCD_REDRAW_BYTES = 34;

   function automatic logic [7:0] lcd_init_byte(input logic [2:0] idx);
      logic [7:0] b;
      case (idx)
         3'd0:    b = LCD_INIT_0;
         3'd1:    b = LCD_INIT_1;
         3'd2:    b = LCD_INIT_2;
         3'd3:    b = LCD_INIT_3;
         3'd4:    b = LCD_INIT_4;
         default: b = LCD_INIT_5;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/lcd_byte_sender.sv
// One-byte ena/done handshake towards the LCD writer. Accepts a byte on start
// when ready, holds it with ena high until done is seen, then waits for done to
// fall before accepting the next byte (works with pulse or level done).
module lcd_byte_sender
   import lcd_pkg::*;
(
   input  logic       clk_1MHz,
   input  logic       rst_n,
   input  logic       start,
   input  logic [7:0] tx_byte,
   input  logic       tx_rs,
   input  logic       done,
   output logic       ready,
   output logic       ack,
   output logic [7:0] data,
   output logic       cmd_data,
   output logic       ena
);

   snd_state_t state, state_nxt;
   logic [7:0] data_nxt;
   logic       rs_nxt;
   logic       ena_nxt;

   // A new byte may be loaded when idle, or when releasing and done has already fallen
   assign ready = (state == SND_IDLE) || ((state == SND_RELEASE) && !done);
   assign ack   = (state == SND_REQ) && done;

   // Handshake state and the byte presented to the writer
   always_ff @(posedge clk_1MHz or negedge rst_n) begin
      if (!rst_n) begin
         state    <= SND_IDLE;
         data     <= 8'h00;
         cmd_data <= 1'b0;
         ena      <= 1'b0;
      end else begin
         state    <= state_nxt;
         data     <= data_nxt;
         cmd_data <= rs_nxt;
         ena      <= ena_nxt;
      end
   end

   // Next-state: load on start, drop ena on done, re-arm once done is low
   always_comb begin
      state_nxt = state;
      data_nxt  = data;
      rs_nxt    = cmd_data;
      ena_nxt   = ena;
      case (state)
         SND_IDLE: begin
            if (start) begin
               data_nxt  = tx_byte;
               rs_nxt    = tx_rs;
               ena_nxt   = 1'b1;
               state_nxt = SND_REQ;
            end
         end
         SND_REQ: begin
            if (done) begin
               ena_nxt   = 1'b0;
               state_nxt = SND_RELEASE;
            end
         end
         SND_RELEASE: begin
            if (!done) begin
               if (start) begin
                  data_nxt  = tx_byte;
                  rs_nxt    = tx_rs;
                  ena_nxt   = 1'b1;
                  state_nxt = SND_REQ;
               end else begin
                  state_nxt = SND_IDLE;
               end
            end
         end
         default: begin
            ena_nxt   = 1'b0;
            state_nxt = SND_IDLE;
         end
      endcase
   end

endmodule

// File: rtl/lcd_display_ctrl.sv
// Sequencer for a 2x16 HD44780 LCD behind a PCF8574 backpack: power-up wait,
// 4-bit init commands, clear delay, then full-screen redraws from a snapshot
// of the two row buses on every refresh request.
module lcd_display_ctrl
   import lcd_pkg::*;
#(
   parameter logic [6:0] I2C_ADDR       = 7'h27,
   parameter int         POWERUP_CYCLES = 50000,
   parameter int         CLEAR_CYCLES   = 2000
) (
   input  logic         clk_1MHz,
   input  logic         rst_n,
   input  logic [127:0] row1,
   input  logic [127:0] row2,
   input  logic         refresh,
   input  logic         done,
   output logic [7:0]   data,
   output logic         cmd_data,
   output logic         ena,
   output logic [6:0]   i2c_addr,
   output logic         busy,
   output logic         init_done
);

   localparam int CNT_MAX = (POWERUP_CYCLES > CLEAR_CYCLES) ? POWERUP_CYCLES : CLEAR_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] PWR_LAST  = CNT_W'(POWERUP_CYCLES - 1);
   localparam logic [CNT_W-1:0] CLR_LAST  = CNT_W'(CLEAR_CYCLES - 1);
   localparam logic [5:0]       SENT_LAST = 6'(LCD_REDRAW_BYTES - 1);

   lcd_state_t       state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [2:0]       init_idx, init_idx_nxt;
   logic [3:0]       char_idx, char_idx_nxt;
   logic             row_sel, row_sel_nxt;
   logic [5:0]       sent_cnt, sent_cnt_nxt;
   logic             pending, pending_nxt;
   logic             init_done_nxt;
   logic             snap_load;
   logic             begin_redraw;
   logic [255:0]     snap;

   logic             snd_start;
   logic [7:0]       snd_byte;
   logic             snd_rs;
   logic             snd_ready;
   logic             snd_ack;

   logic [127:0]     row_bits;
   logic [6:0]       char_lsb;
   logic [7:0]       cur_char;

   assign i2c_addr = I2C_ADDR;
   assign busy     = (state != IDLE);

   // Column 0 sits in the top byte of each row, so index from the MSB end
   assign row_bits = row_sel ? snap[127:0] : snap[255:128];
   assign char_lsb = {4'd15 - char_idx, 3'b000};
   assign cur_char = row_bits[char_lsb +: 8];

   lcd_byte_sender u_sender (
      .clk_1MHz (clk_1MHz),
      .rst_n    (rst_n),
      .start    (snd_start),
      .tx_byte  (snd_byte),
      .tx_rs    (snd_rs),
      .done     (done),
      .ready    (snd_ready),
      .ack      (snd_ack),
      .data     (data),
      .cmd_data (cmd_data),
      .ena      (ena)
   );

   // Sequencer state, delay counter, byte indices and the refresh-pending flag
   always_ff @(posedge clk_1MHz or negedge rst_n) begin
      if (!rst_n) begin
         state     <= PWR_WAIT;
         cnt       <= '0;
         init_idx  <= 3'd0;
         char_idx  <= 4'd0;
         row_sel   <= 1'b0;
         sent_cnt  <= 6'd0;
         pending   <= 1'b0;
         init_done <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         init_idx  <= init_idx_nxt;
         char_idx  <= char_idx_nxt;
         row_sel   <= row_sel_nxt;
         sent_cnt  <= sent_cnt_nxt;
         pending   <= pending_nxt;
         init_done <= init_done_nxt;
      end
   end

   // Text snapshot taken when a redraw starts so mid-redraw edits cannot tear the screen
   always_ff @(posedge clk_1MHz or negedge rst_n) begin
      if (!rst_n) begin
         snap <= '0;
      end else if (snap_load) begin
         snap <= {row1, row2};
      end
   end

   // Next-state and byte selection; a redraw start issues the row-1 address immediately
   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt;
      init_idx_nxt  = init_idx;
      char_idx_nxt  = char_idx;
      row_sel_nxt   = row_sel;
      sent_cnt_nxt  = sent_cnt;
      pending_nxt   = pending | refresh;
      init_done_nxt = init_done;
      snap_load     = 1'b0;
      begin_redraw  = 1'b0;
      snd_start     = 1'b0;
      snd_byte      = 8'h00;
      snd_rs        = 1'b0;

      case (state)
         PWR_WAIT: begin
            if (cnt == PWR_LAST) begin
               cnt_nxt      = '0;
               init_idx_nxt = 3'd0;
               state_nxt    = INIT_SEND;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         INIT_SEND: begin
            snd_byte  = lcd_init_byte(init_idx);
            snd_start = snd_ready;
            if (snd_ack) begin
               if (init_idx == LCD_INIT_LAST) begin
                  cnt_nxt   = '0;
                  state_nxt = CLR_WAIT;
               end else begin
                  init_idx_nxt = init_idx + 3'd1;
               end
            end
         end
         CLR_WAIT: begin
            if (cnt != CLR_LAST) begin
               cnt_nxt = cnt + CNT_W'(1);
            end else if (snd_ready) begin
               init_done_nxt = 1'b1;
               begin_redraw  = 1'b1;
            end
         end
         IDLE: begin
            if ((refresh || pending) && snd_ready) begin
               begin_redraw = 1'b1;
            end
         end
         ROW_ADDR: begin
            snd_byte  = row_sel ? LCD_CMD_ROW2 : LCD_CMD_ROW1;
            snd_start = snd_ready;
            if (snd_ack) begin
               sent_cnt_nxt = sent_cnt + 6'd1;
               state_nxt    = ROW_CHARS;
            end
         end
         ROW_CHARS: begin
            snd_byte  = cur_char;
            snd_rs    = 1'b1;
            snd_start = snd_ready;
            if (snd_ack) begin
               sent_cnt_nxt = sent_cnt + 6'd1;
               char_idx_nxt = char_idx + 4'd1;
               if (sent_cnt == SENT_LAST) begin
                  state_nxt = IDLE;
               end else if (char_idx == 4'd15) begin
                  row_sel_nxt = 1'b1;
                  state_nxt   = ROW_ADDR;
               end
            end
         end
         default: begin
            cnt_nxt   = '0;
            state_nxt = PWR_WAIT;
         end
      endcase

      if (begin_redraw) begin
         snap_load    = 1'b1;
         pending_nxt  = 1'b0;
         row_sel_nxt  = 1'b0;
         char_idx_nxt = 4'd0;
         sent_cnt_nxt = 6'd0;
         snd_start    = 1'b1;
         snd_byte     = LCD_CMD_ROW1;
         snd_rs       = 1'b0;
         state_nxt    = ROW_ADDR;
      end
   end

endmodule

// File: tb/tb_lcd_display_ctrl.sv
// Directed bench for lcd_display_ctrl with a writer model that answers each
// ena with done a fixed number of cycles later (pulse or level).
`timescale 1ns/1ps
module tb_lcd_display_ctrl;

   localparam int POWERUP    = 20;
   localparam int CLEAR      = 10;
   localparam int DONE_DELAY = 5;

   logic         clk_1MHz = 1'b0;
   logic         rst_n    = 1'b1;
   logic [127:0] row1     = '0;
   logic [127:0] row2     = '0;
   logic         refresh  = 1'b0;
   logic         done     = 1'b0;
   logic [7:0]   data;
   logic         cmd_data;
   logic         ena;
   logic [6:0]   i2c_addr;
   logic         busy;
   logic         init_done;

   int n_compared   = 0;
   int n_mismatched = 0;
   int done_len     = 1;
   int violations   = 0;

   logic [8:0] log_q[$];
   logic [8:0] exp_b [0:33];
   logic [7:0] init_exp [0:5] = '{8'h33, 8'h32, 8'h28, 8'h0C, 8'h06, 8'h01};

   localparam logic [127:0] TEXT_HELLO = "HELLO WORLD     ";
   localparam logic [127:0] TEXT_BYE   = "GOODBYE MOON    ";
   localparam logic [127:0] TEXT_HEX   = "0123456789ABCDEF";

   always #5 clk_1MHz = ~clk_1MHz;

   lcd_display_ctrl #(
      .I2C_ADDR       (7'h27),
      .POWERUP_CYCLES (POWERUP),
      .CLEAR_CYCLES   (CLEAR)
   ) dut (
      .clk_1MHz  (clk_1MHz),
      .rst_n     (rst_n),
      .row1      (row1),
      .row2      (row2),
      .refresh   (refresh),
      .done      (done),
      .data      (data),
      .cmd_data  (cmd_data),
      .ena       (ena),
      .i2c_addr  (i2c_addr),
      .busy      (busy),
      .init_done (init_done)
   );

   // Writer model: done DONE_DELAY cycles after ena, held done_len cycles; logs each byte
   initial begin : writer_model
      int wr_wait;
      int wr_hold;
      wr_wait = 0;
      wr_hold = 0;
      forever begin
         @(posedge clk_1MHz);
         #1;
         if (!rst_n) begin
            done    = 1'b0;
            wr_wait = 0;
            wr_hold = 0;
         end else begin
            if (done && ena) violations++;
            if (wr_hold > 0) begin
               wr_hold--;
               if (wr_hold == 0) done = 1'b0;
            end else if (ena) begin
               if (wr_wait == DONE_DELAY - 1) begin
                  done    = 1'b1;
                  wr_hold = done_len;
                  wr_wait = 0;
                  log_q.push_back({cmd_data, data});
               end else begin
                  wr_wait++;
               end
            end
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched + 1);
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic wait_bytes(input int n, input int budget, output bit ok);
      int g;
      g = 0;
      while (log_q.size() < n && g < budget) begin
         @(posedge clk_1MHz);
         #2;
         g++;
      end
      ok = (log_q.size() >= n);
   endtask

   task automatic pulse_refresh();
      @(negedge clk_1MHz);
      refresh = 1'b1;
      @(negedge clk_1MHz);
      refresh = 1'b0;
   endtask

   task automatic fill_expected(input logic [127:0] r1, input logic [127:0] r2);
      exp_b[0]  = {1'b0, 8'h80};
      exp_b[17] = {1'b0, 8'hC0};
      for (int c = 0; c < 16; c++) begin
         exp_b[1 + c]  = {1'b1, r1[127 - 8*c -: 8]};
         exp_b[18 + c] = {1'b1, r2[127 - 8*c -: 8]};
      end
   endtask

   task automatic test_reset();
      bit ena_seen;
      row1 = TEXT_HELLO;
      row2 = TEXT_HEX;
      #1 rst_n = 1'b0;
      log_q.delete();
      repeat (3) @(posedge clk_1MHz);
      #2;
      n_compared++; if (data !== 8'h00) begin n_mismatched++; $display("[TB] FAIL rst_data: got %h expected 00", data); end
      n_compared++; if (cmd_data !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rst_cmd_data: got %b expected 0", cmd_data); end
      n_compared++; if (ena !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rst_ena: got %b expected 0", ena); end
      n_compared++; if (i2c_addr !== 7'h27) begin n_mismatched++; $display("[TB] FAIL rst_i2c_addr: got %h expected 27", i2c_addr); end
      n_compared++; if (busy !== 1'b1) begin n_mismatched++; $display("[TB] FAIL rst_busy: got %b expected 1", busy); end
      n_compared++; if (init_done !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rst_init_done: got %b expected 0", init_done); end
      @(negedge clk_1MHz);
      rst_n = 1'b1;
      ena_seen = 1'b0;
      repeat (POWERUP) begin
         @(posedge clk_1MHz);
         #2;
         if (ena) ena_seen = 1'b1;
      end
      n_compared++; if (ena_seen !== 1'b0) begin n_mismatched++; $display("[TB] FAIL pwr_wait_ena: got %b expected 0", ena_seen); end
      @(posedge clk_1MHz);
      #2;
      n_compared++; if (ena !== 1'b1) begin n_mismatched++; $display("[TB] FAIL first_ena_time: got %b expected 1", ena); end
      n_compared++; if (data !== 8'h33) begin n_mismatched++; $display("[TB] FAIL first_byte: got %h expected 33", data); end
      n_compared++; if (cmd_data !== 1'b0) begin n_mismatched++; $display("[TB] FAIL first_rs: got %b expected 0", cmd_data); end
      n_compared++; if (i2c_addr !== 7'h27) begin n_mismatched++; $display("[TB] FAIL run_i2c_addr: got %h expected 27", i2c_addr); end
   endtask

   task automatic test_init_sequence();
      bit ok;
      bit ena_seen;
      bit id_seen;
      wait_bytes(6, 200, ok);
      n_compared++; if (ok !== 1'b1) begin n_mismatched++; $display("[TB] FAIL init_timeout: got %0d bytes expected 6", log_q.size()); end
      if (ok) begin
         for (int i = 0; i < 6; i++) begin
            n_compared++;
            if (log_q[i] !== {1'b0, init_exp[i]}) begin
               n_mismatched++;
               $display("[TB] FAIL init_byte[%0d]: got %h expected %h", i, log_q[i], {1'b0, init_exp[i]});
            end
         end
      end
      @(posedge clk_1MHz);
      #2;
      n_compared++; if (ena !== 1'b0) begin n_mismatched++; $display("[TB] FAIL clr_ena_drop: got %b expected 0", ena); end
      ena_seen = 1'b0;
      id_seen  = 1'b0;
      repeat (CLEAR - 1) begin
         @(posedge clk_1MHz);
         #2;
         if (ena) ena_seen = 1'b1;
         if (init_done) id_seen = 1'b1;
      end
      n_compared++; if (ena_seen !== 1'b0) begin n_mismatched++; $display("[TB] FAIL clr_wait_ena: got %b expected 0", ena_seen); end
      n_compared++; if (id_seen !== 1'b0) begin n_mismatched++; $display("[TB] FAIL clr_wait_init_done: got %b expected 0", id_seen); end
      @(posedge clk_1MHz);
      #2;
      n_compared++; if (ena !== 1'b1) begin n_mismatched++; $display("[TB] FAIL redraw_ena: got %b expected 1", ena); end
      n_compared++; if (data !== 8'h80) begin n_mismatched++; $display("[TB] FAIL redraw_addr: got %h expected 80", data); end
      n_compared++; if (init_done !== 1'b1) begin n_mismatched++; $display("[TB] FAIL init_done_rise: got %b expected 1", init_done); end
   endtask

   task automatic test_auto_redraw();
      bit ok;
      fill_expected(TEXT_HELLO, TEXT_HEX);
      wait_bytes(40, 600, ok);
      n_compared++; if (ok !== 1'b1) begin n_mismatched++; $display("[TB] FAIL auto_timeout: got %0d bytes expected 40", log_q.size()); end
      n_compared++; if (busy !== 1'b1) begin n_mismatched++; $display("[TB] FAIL auto_busy_last: got %b expected 1", busy); end
      if (ok) begin
         for (int i = 0; i < 34; i++) begin
            n_compared++;
            if (log_q[6 + i] !== exp_b[i]) begin
               n_mismatched++;
               $display("[TB] FAIL auto_byte[%0d]: got %h expected %h", i, log_q[6 + i], exp_b[i]);
            end
         end
      end
      @(posedge clk_1MHz);
      #2;
      n_compared++; if (busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL auto_busy_fall: got %b expected 0", busy); end
      n_compared++; if (ena !== 1'b0) begin n_mismatched++; $display("[TB] FAIL auto_ena_end: got %b expected 0", ena); end
      n_compared++; if (init_done !== 1'b1) begin n_mismatched++; $display("[TB] FAIL auto_init_done: got %b expected 1", init_done); end
   endtask

   task automatic test_snapshot();
      bit ok;
      repeat (3) @(posedge clk_1MHz);
      #2;
      log_q.delete();
      n_compared++; if (busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL snap_idle_busy: got %b expected 0", busy); end
      fill_expected(TEXT_HELLO, TEXT_HEX);
      @(negedge clk_1MHz);
      refresh = 1'b1;
      @(posedge clk_1MHz);
      #2;
      refresh = 1'b0;
      n_compared++; if (ena !== 1'b1) begin n_mismatched++; $display("[TB] FAIL refresh_ena: got %b expected 1", ena); end
      n_compared++; if (data !== 8'h80) begin n_mismatched++; $display("[TB] FAIL refresh_addr: got %h expected 80", data); end
      n_compared++; if (busy !== 1'b1) begin n_mismatched++; $display("[TB] FAIL refresh_busy: got %b expected 1", busy); end
      wait_bytes(5, 100, ok);
      row1 = TEXT_BYE;
      wait_bytes(34, 600, ok);
      n_compared++; if (ok !== 1'b1) begin n_mismatched++; $display("[TB] FAIL snap_timeout: got %0d bytes expected 34", log_q.size()); end
      if (ok) begin
         for (int i = 0; i < 34; i++) begin
            n_compared++;
            if (log_q[i] !== exp_b[i]) begin
               n_mismatched++;
               $display("[TB] FAIL snap_old_byte[%0d]: got %h expected %h", i, log_q[i], exp_b[i]);
            end
         end
      end
      repeat (3) @(posedge clk_1MHz);
      #2;
      n_compared++; if (busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL snap_busy_end: got %b expected 0", busy); end
      log_q.delete();
      fill_expected(TEXT_BYE, TEXT_HEX);
      pulse_refresh();
      wait_bytes(34, 600, ok);
      n_compared++; if (ok !== 1'b1) begin n_mismatched++; $display("[TB] FAIL snap_new_timeout: got %0d bytes expected 34", log_q.size()); end
      if (ok) begin
         for (int i = 0; i < 34; i++) begin
            n_compared++;
            if (log_q[i] !== exp_b[i]) begin
               n_mismatched++;
               $display("[TB] FAIL snap_new_byte[%0d]: got %h expected %h", i, log_q[i], exp_b[i]);
            end
         end
      end
      repeat (3) @(posedge clk_1MHz);
      #2;
   endtask

   task automatic test_refresh_pending();
      bit ok;
      log_q.delete();
      fill_expected(TEXT_BYE, TEXT_HEX);
      pulse_refresh();
      wait_bytes(2, 100, ok);
      pulse_refresh();
      wait_bytes(10, 200, ok);
      pulse_refresh();
      wait_bytes(20, 200, ok);
      pulse_refresh();
      wait_bytes(68, 1200, ok);
      n_compared++; if (ok !== 1'b1) begin n_mismatched++; $display("[TB] FAIL pend_timeout: got %0d bytes expected 68", log_q.size()); end
      repeat (60) @(posedge clk_1MHz);
      #2;
      n_compared++; if (log_q.size() !== 68) begin n_mismatched++; $display("[TB] FAIL pend_byte_count: got %0d expected 68", log_q.size()); end
      n_compared++; if (busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL pend_busy_end: got %b expected 0", busy); end
      n_compared++; if (ena !== 1'b0) begin n_mismatched++; $display("[TB] FAIL pend_ena_end: got %b expected 0", ena); end
      if (ok) begin
         for (int i = 0; i < 68; i++) begin
            n_compared++;
            if (log_q[i] !== exp_b[i % 34]) begin
               n_mismatched++;
               $display("[TB] FAIL pend_byte[%0d]: got %h expected %h", i, log_q[i], exp_b[i % 34]);
            end
         end
      end
   endtask

   task automatic test_level_done();
      bit ok;
      done_len   = 4;
      violations = 0;
      log_q.delete();
      fill_expected(TEXT_BYE, TEXT_HEX);
      pulse_refresh();
      wait_bytes(34, 1000, ok);
      n_compared++; if (ok !== 1'b1) begin n_mismatched++; $display("[TB] FAIL level_timeout: got %0d bytes expected 34", log_q.size()); end
      repeat (12) @(posedge clk_1MHz);
      #2;
      n_compared++; if (violations !== 0) begin n_mismatched++; $display("[TB] FAIL level_ena_while_done: got %0d expected 0", violations); end
      n_compared++; if (log_q.size() !== 34) begin n_mismatched++; $display("[TB] FAIL level_byte_count: got %0d expected 34", log_q.size()); end
      n_compared++; if (busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL level_busy_end: got %b expected 0", busy); end
      if (ok) begin
         for (int i = 0; i < 34; i++) begin
            n_compared++;
            if (log_q[i] !== exp_b[i]) begin
               n_mismatched++;
               $display("[TB] FAIL level_byte[%0d]: got %h expected %h", i, log_q[i], exp_b[i]);
            end
         end
      end
      done_len = 1;
   endtask

   task automatic test_reset_mid();
      bit ok;
      bit ena_seen;
      log_q.delete();
      pulse_refresh();
      wait_bytes(20, 400, ok);
      n_compared++; if (ok !== 1'b1) begin n_mismatched++; $display("[TB] FAIL mid_timeout: got %0d bytes expected 20", log_q.size()); end
      @(posedge clk_1MHz);
      #3;
      rst_n = 1'b0;
      #1;
      n_compared++; if (ena !== 1'b0) begin n_mismatched++; $display("[TB] FAIL mid_rst_ena: got %b expected 0", ena); end
      n_compared++; if (busy !== 1'b1) begin n_mismatched++; $display("[TB] FAIL mid_rst_busy: got %b expected 1", busy); end
      n_compared++; if (init_done !== 1'b0) begin n_mismatched++; $display("[TB] FAIL mid_rst_init_done: got %b expected 0", init_done); end
      n_compared++; if (data !== 8'h00) begin n_mismatched++; $display("[TB] FAIL mid_rst_data: got %h expected 00", data); end
      repeat (2) @(posedge clk_1MHz);
      #2;
      log_q.delete();
      @(negedge clk_1MHz);
      rst_n = 1'b1;
      ena_seen = 1'b0;
      repeat (POWERUP) begin
         @(posedge clk_1MHz);
         #2;
         if (ena) ena_seen = 1'b1;
      end
      n_compared++; if (ena_seen !== 1'b0) begin n_mismatched++; $display("[TB] FAIL mid_pwr_wait_ena: got %b expected 0", ena_seen); end
      @(posedge clk_1MHz);
      #2;
      n_compared++; if (ena !== 1'b1) begin n_mismatched++; $display("[TB] FAIL mid_first_ena: got %b expected 1", ena); end
      n_compared++; if (data !== 8'h33) begin n_mismatched++; $display("[TB] FAIL mid_first_byte: got %h expected 33", data); end
      wait_bytes(6, 200, ok);
      n_compared++; if (ok !== 1'b1) begin n_mismatched++; $display("[TB] FAIL mid_init_timeout: got %0d bytes expected 6", log_q.size()); end
      if (ok) begin
         for (int i = 0; i < 6; i++) begin
            n_compared++;
            if (log_q[i] !== {1'b0, init_exp[i]}) begin
               n_mismatched++;
               $display("[TB] FAIL mid_init_byte[%0d]: got %h expected %h", i, log_q[i], {1'b0, init_exp[i]});
            end
         end
      end
   endtask

   initial begin : main
      $display("[TB] lcd_display_ctrl directed bench start");
      test_reset();
      test_init_sequence();
      test_auto_redraw();
      test_snapshot();
      test_refresh_pending();
      test_level_done();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
